// File: rtl/cpu_phase_ctrl_pkg.sv
// Shared types and defaults for the CPU instruction-phase sequencer.
// Imported by cpu_phase_ctrl.
package cpu_phase_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StFetch = 3'd1,
    StExec1 = 3'd2,
    StExec2 = 3'd3,
    StExtw  = 3'd4,
    StHalt  = 3'd5
  } state_e;

  localparam int unsigned MaxGntDefault = 4;
  localparam int unsigned CntWDefault   = 16;

  function automatic logic is_stopped(state_e s);
    return (s == StIdle) || (s == StHalt);
  endfunction

endpackage

// File: rtl/cpu_phase_ctrl.sv
// Instruction-phase sequencer: one-hot FETCH/EXEC1/EXEC2 strobes, bounded data-RAM
// grant to one external requester, and a retired-instruction counter.
module cpu_phase_ctrl
  import cpu_phase_ctrl_pkg::*;
#(
  parameter int unsigned MaxGnt = MaxGntDefault,
  parameter int unsigned CntW   = CntWDefault
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            run_i,
  input  logic            e2_i,
  input  logic            halt_req_i,
  input  logic            ext_req_i,
  output logic            ext_gnt_o,
  output logic            fetch_o,
  output logic            exec1_o,
  output logic            exec2_o,
  output logic            halted_o,
  output logic [CntW-1:0] instr_count_o
);

  localparam int unsigned GntW = (MaxGnt > 1) ? $clog2(MaxGnt) : 1;
  localparam logic [GntW-1:0] GntLast = GntW'(MaxGnt - 1);

  state_e          state_q, state_d;
  state_e          ret_q, ret_d;
  logic [GntW-1:0] gnt_cnt_q, gnt_cnt_d;
  logic            fair_q, fair_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fetch_q, exec1_q, exec2_q, gnt_q, halted_q;
  logic            retire;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    gnt_cnt_d = gnt_cnt_q;
    fair_d    = fair_q;
    cnt_d     = cnt_q;
    retire    = 1'b0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (ext_req_i) begin
          state_d   = StExtw;
          ret_d     = state_q;
          gnt_cnt_d = '0;
        end else if (run_i) begin
          state_d = StFetch;
        end
      end
      StFetch: state_d = StExec1;
      StExec1: begin
        if (halt_req_i) begin
          state_d = StHalt;
          cnt_d   = cnt_q + CntW'(1);
        end else if (e2_i) begin
          state_d = StExec2;
        end else begin
          retire = 1'b1;
        end
      end
      StExec2: retire = 1'b1;
      StExtw: begin
        gnt_cnt_d = gnt_cnt_q + GntW'(1);
        if (!ext_req_i) begin
          state_d = ret_q;
        end else if (ret_q == StFetch && gnt_cnt_q == GntLast) begin
          // Window exhausted: hand the port back so the CPU makes progress.
          state_d = StFetch;
          fair_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (retire) begin
      cnt_d = cnt_q + CntW'(1);
      if (ext_req_i && !fair_q) begin
        state_d   = StExtw;
        ret_d     = StFetch;
        gnt_cnt_d = '0;
      end else begin
        state_d = StFetch;
        fair_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ret_q     <= StIdle;
      gnt_cnt_q <= '0;
      fair_q    <= 1'b0;
      cnt_q     <= '0;
      fetch_q   <= 1'b0;
      exec1_q   <= 1'b0;
      exec2_q   <= 1'b0;
      gnt_q     <= 1'b0;
      halted_q  <= 1'b1;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      gnt_cnt_q <= gnt_cnt_d;
      fair_q    <= fair_d;
      cnt_q     <= cnt_d;
      fetch_q   <= (state_d == StFetch);
      exec1_q   <= (state_d == StExec1);
      exec2_q   <= (state_d == StExec2);
      gnt_q     <= (state_d == StExtw);
      halted_q  <= is_stopped(state_d);
    end
  end

  assign fetch_o       = fetch_q;
  assign exec1_o       = exec1_q;
  assign exec2_o       = exec2_q;
  assign ext_gnt_o     = gnt_q;
  assign halted_o      = halted_q;
  assign instr_count_o = cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert ($countones({fetch_q, exec1_q, exec2_q, gnt_q}) <= 1)
        else $error("phase strobes and ext_gnt not mutually exclusive");
    end
  end

endmodule

// File: tb/tb_cpu_phase_ctrl.sv
// Directed bench for cpu_phase_ctrl: behavioural model compared every cycle,
// plus hand-computed literal checkpoints.
module tb_cpu_phase_ctrl;

  localparam int unsigned MaxGnt = 4;
  localparam int unsigned CntW   = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            run = 1'b0;
  logic            e2 = 1'b0;
  logic            halt_req = 1'b0;
  logic            ext_req = 1'b0;
  logic            ext_gnt, fetch, exec1, exec2, halted;
  logic [CntW-1:0] instr_count;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;
  int cyc     = 0;

  always #5 clk = ~clk;

  cpu_phase_ctrl #(
    .MaxGnt(MaxGnt),
    .CntW  (CntW)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .run_i        (run),
    .e2_i         (e2),
    .halt_req_i   (halt_req),
    .ext_req_i    (ext_req),
    .ext_gnt_o    (ext_gnt),
    .fetch_o      (fetch),
    .exec1_o      (exec1),
    .exec2_o      (exec2),
    .halted_o     (halted),
    .instr_count_o(instr_count)
  );

  // Model: IDLE and HALT behave identically, so one "stopped" flag covers both.
  bit              m_stopped = 1'b1;
  bit              m_grant   = 1'b0;
  bit              m_limited = 1'b0;
  bit              m_owe     = 1'b0;
  int              m_budget  = 0;
  int              m_phase   = 0;
  logic [CntW-1:0] m_count   = '0;

  task automatic m_retire();
    m_count = m_count + 1'b1;
    if (ext_req && !m_owe) begin
      m_grant   = 1'b1;
      m_limited = 1'b1;
      m_budget  = MaxGnt;
    end else begin
      m_phase = 0;
      m_owe   = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      m_stopped = 1'b1;
      m_grant   = 1'b0;
      m_owe     = 1'b0;
      m_phase   = 0;
      m_count   = '0;
    end else if (m_grant) begin
      if (!ext_req) begin
        m_grant = 1'b0;
        m_phase = 0;
      end else if (m_limited) begin
        m_budget = m_budget - 1;
        if (m_budget == 0) begin
          m_grant = 1'b0;
          m_phase = 0;
          m_owe   = 1'b1;
        end
      end
    end else if (m_stopped) begin
      if (ext_req) begin
        m_grant   = 1'b1;
        m_limited = 1'b0;
      end else if (run) begin
        m_stopped = 1'b0;
        m_phase   = 0;
      end
    end else begin
      case (m_phase)
        0: m_phase = 1;
        1: begin
          if (halt_req) begin
            m_count   = m_count + 1'b1;
            m_stopped = 1'b1;
          end else if (e2) begin
            m_phase = 2;
          end else begin
            m_retire();
          end
        end
        default: m_retire();
      endcase
    end
  end

  always @(negedge clk) begin
    logic [4+CntW:0] exp_v, got_v;
    if (chk_en) begin
      exp_v = {!m_grant && !m_stopped && m_phase == 0,
               !m_grant && !m_stopped && m_phase == 1,
               !m_grant && !m_stopped && m_phase == 2,
               m_grant, m_stopped && !m_grant, m_count};
      got_v = {fetch, exec1, exec2, ext_gnt, halted, instr_count};
      n_total++;
      if (got_v === exp_v) n_pass++;
      else $display("FAIL model cycle %0d: {F,E1,E2,G,H,cnt} got %b want %b", cyc, got_v, exp_v);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, want);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    int g;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_idle", {27'd0, fetch, exec1, exec2, ext_gnt, halted}, 32'h1);
      check("reset_cnt", 32'(instr_count), 32'd0);
    end

    run = 1'b1;
    tick();
    check("first_fetch", 32'(fetch), 32'd1);
    repeat (6) tick();
    check("three_instr_cnt", 32'(instr_count), 32'd3);
    check("three_instr_fetch", 32'(fetch), 32'd1);

    e2 = 1'b1;
    tick();
    tick();
    check("e2_exec2", 32'(exec2), 32'd1);
    e2 = 1'b0;
    tick();
    check("e2_cnt", 32'(instr_count), 32'd4);
    check("e2_fetch", 32'(fetch), 32'd1);

    ext_req = 1'b1;
    tick();
    tick();
    check("grant_latency", 32'(ext_gnt), 32'd1);
    check("grant_cnt5", 32'(instr_count), 32'd5);
    g = 1;
    repeat (11) begin
      tick();
      g += int'(ext_gnt);
    end
    check("bounded_grants", 32'(g), 32'd8);
    check("fair_cnt", 32'(instr_count), 32'd7);
    ext_req = 1'b0;
    tick();
    check("release_fetch", {30'd0, fetch, ext_gnt}, 32'h2);

    halt_req = 1'b1;
    e2       = 1'b1;
    tick();
    tick();
    check("halt_no_exec2", {30'd0, exec2, halted}, 32'h1);
    check("halt_cnt", 32'(instr_count), 32'd8);
    halt_req = 1'b0;
    e2       = 1'b0;
    run      = 1'b0;
    tick();
    ext_req = 1'b1;
    g = 0;
    repeat (10) begin
      tick();
      g += int'(ext_gnt);
    end
    check("halt_unlimited", 32'(g), 32'd10);
    ext_req = 1'b0;
    tick();
    check("back_to_halt", {30'd0, ext_gnt, halted}, 32'h1);
    run = 1'b1;
    tick();
    check("resume_fetch", 32'(fetch), 32'd1);

    ext_req = 1'b1;
    tick();
    tick();
    check("extw_before_rst", 32'(ext_gnt), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_in_extw", {27'd0, ext_gnt, halted, instr_count}, {27'd0, 2'b01, 4'd0});
    rst     = 1'b0;
    ext_req = 1'b0;
    e2      = 1'b1;
    tick();
    tick();
    tick();
    check("exec2_before_rst", 32'(exec2), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_in_exec2", {27'd0, exec2, halted, instr_count}, {27'd0, 2'b01, 4'd0});
    rst = 1'b0;
    e2  = 1'b0;

    repeat (33) tick();
    check("wrap_cnt", 32'(instr_count), 32'd0);
    check("wrap_fetch", 32'(fetch), 32'd1);
    tick();
    tick();
    check("post_wrap_cnt", 32'(instr_count), 32'd1);

    @(posedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
